// File: rtl/dadd_step_seq.sv
// Span sequencer for the four-lane saturating adder array: loads lane accumulators,
// hands each pixel value downstream, then steps by fraction and integer increments.
module dadd_step_seq #(
    parameter int CNT_W   = 16,
    parameter bit FRAC_EN = 1'b1
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [1:0]       int_mode,
    input  logic             frac_en,
    input  logic             abort,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [2:0]       daddmode,
    output logic             carry_en,
    output logic             addb_zero,
    output logic             frac_we,
    output logic             int_we,
    output logic             out_valid,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_FRAC,
        S_INT,
        S_DONE
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] remaining_next;
    logic [1:0]       int_mode_reg;
    logic             frac_on_reg;
    logic             load_cfg;
    logic             abort_hit;

    function automatic logic [2:0] int_daddmode(input logic [1:0] mode);
        case (mode)
            2'd0:    return 3'b101;
            2'd1:    return 3'b110;
            2'd2:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining;
        load_cfg       = 1'b0;
        abort_hit      = abort && (state_reg != S_IDLE);
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_next     = S_LOAD;
                        remaining_next = len;
                        load_cfg       = 1'b1;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_LOAD: state_next = S_EMIT;
            S_EMIT: begin
                if (out_ready) begin
                    if (remaining != '0)
                        remaining_next = remaining - 1'b1;
                    if (remaining == CNT_W'(1))
                        state_next = S_DONE;
                    else
                        state_next = frac_on_reg ? S_FRAC : S_INT;
                end
            end
            S_FRAC: state_next = S_INT;
            S_INT:  state_next = S_EMIT;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // Cancellation overrides everything, including a same-cycle handshake.
        if (abort_hit) begin
            state_next     = S_IDLE;
            remaining_next = '0;
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            remaining    <= '0;
            int_mode_reg <= 2'd0;
            frac_on_reg  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            daddmode     <= 3'b000;
            carry_en     <= 1'b0;
            addb_zero    <= 1'b0;
            frac_we      <= 1'b0;
            int_we       <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            state_reg <= state_next;
            remaining <= remaining_next;
            if (load_cfg) begin
                int_mode_reg <= int_mode;
                frac_on_reg  <= frac_en & FRAC_EN;
            end
            busy      <= (state_next != S_IDLE);
            done      <= (state_next == S_DONE);
            aborted   <= abort_hit;
            addb_zero <= (state_next == S_LOAD);
            frac_we   <= (state_next == S_LOAD) || (state_next == S_FRAC);
            int_we    <= (state_next == S_LOAD) || (state_next == S_INT);
            carry_en  <= (state_next == S_FRAC);
            out_valid <= (state_next == S_EMIT);
            daddmode  <= (state_next == S_INT) ? int_daddmode(int_mode_reg) : 3'b000;
        end
    end

endmodule

// File: tb/tb_dadd_step_seq.sv
// Randomized scoreboard bench for dadd_step_seq: the driver queues the expected span
// events, a negedge monitor pops and compares them as the sequencer produces them.
module tb_dadd_step_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic [1:0]  int_mode = '0;
    logic        frac_en = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic        busy, done, aborted, carry_en, addb_zero, frac_we, int_we, out_valid;
    logic [2:0]  daddmode;
    logic [15:0] remaining;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int kind;   // 0 pixel handshake, 1 done pulse, 2 aborted pulse
        int rem;
        int lat;
        int nload;
        int nfrac;
        int nint;
        int dm;
    } rec_t;
    rec_t q[$];

    dadd_step_seq #(.CNT_W(16), .FRAC_EN(1'b1)) dut (
        .sys_clk(clk), .reset_n(reset_n), .start(start), .len(len),
        .int_mode(int_mode), .frac_en(frac_en), .abort(abort), .out_ready(out_ready),
        .busy(busy), .done(done), .aborted(aborted), .daddmode(daddmode),
        .carry_en(carry_en), .addb_zero(addb_zero), .frac_we(frac_we), .int_we(int_we),
        .out_valid(out_valid), .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_dm(input int m);
        case (m)
            0: return 5;
            1: return 6;
            2: return 7;
            default: return 0;
        endcase
    endfunction

    // Monitor: counts strobe cycles between span events and checks each event as it appears.
    int cyc = 0, last_ev = 0, valid_lat = 0;
    int n_load = 0, n_frac = 0, n_int = 0, n_carry = 0, n_baddm = 0, int_dm = 0;
    bit seen_valid = 0;

    function automatic void clear_counts();
        n_load = 0; n_frac = 0; n_int = 0; n_carry = 0; n_baddm = 0; int_dm = 0;
        seen_valid = 0;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            clear_counts();
            last_ev = cyc;
        end else begin
            rec_t r;
            if (out_valid && !seen_valid) begin
                valid_lat  = cyc - last_ev;
                seen_valid = 1;
            end
            if (addb_zero) n_load++;
            if (frac_we && !int_we) n_frac++;
            if (carry_en) n_carry++;
            if (int_we && !addb_zero) begin
                n_int++;
                int_dm = int'(daddmode);
            end else if (daddmode != 3'b000) begin
                n_baddm++;
            end
            if (out_valid && out_ready && !abort) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_handshake: got rem=%0d, expected no event", remaining);
                end else begin
                    r = q.pop_front();
                    $display("[TB] pixel rem=%0d lat=%0d dm=%0d", remaining, valid_lat, int_dm);
                    check("event_kind_pix", 0, r.kind);
                    check("pix_remaining", int'(remaining), r.rem);
                    check("pix_latency", valid_lat, r.lat);
                    check("pix_load_cycles", n_load, r.nload);
                    check("pix_frac_cycles", n_frac, r.nfrac);
                    check("pix_int_cycles", n_int, r.nint);
                    check("pix_carry_en_cycles", n_carry, r.nfrac);
                    check("pix_int_daddmode", int_dm, r.dm);
                    check("pix_stray_daddmode", n_baddm, 0);
                end
                clear_counts();
                last_ev = cyc;
            end
            if (done || aborted) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_end: got done=%0d aborted=%0d, expected none", done, aborted);
                end else begin
                    r = q.pop_front();
                    $display("[TB] %s lat=%0d rem=%0d", done ? "done" : "aborted", cyc - last_ev, remaining);
                    check("end_kind", done ? 1 : 2, r.kind);
                    check("end_both_pulses", int'(done & aborted), 0);
                    check("end_latency", cyc - last_ev, r.lat);
                    check("end_remaining", int'(remaining), 0);
                    if (done) check("done_strobes", n_load + n_frac + n_int + n_carry, 0);
                end
                clear_counts();
                last_ev = cyc;
            end
            if ((abort && busy) || (start && !busy)) begin
                clear_counts();
                last_ev = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // amode: 0 none, 1 abort in EMIT of pixel k, 2 abort in INT before pixel k, 3 abort in DONE.
    task automatic run_span(input int ln, input int fe, input int im, input int amode, input int k,
                            input bit rnd, input int stk, input int stn);
        int npix, hs, stc;
        bit fin;
        rec_t r;
        npix = (amode == 1 || amode == 2) ? k : ln;
        for (int i = 0; i < npix; i++) begin
            r.kind  = 0;
            r.rem   = ln - i;
            r.lat   = (i == 0) ? 2 : (fe != 0 ? 3 : 2);
            r.nload = (i == 0) ? 1 : 0;
            r.nfrac = (i > 0 && fe != 0) ? 1 : 0;
            r.nint  = (i > 0) ? 1 : 0;
            r.dm    = (i > 0) ? exp_dm(im) : 0;
            q.push_back(r);
        end
        r = '{kind: 1, rem: 0, lat: 1, nload: 0, nfrac: 0, nint: 0, dm: 0};
        if (amode == 1 || amode == 2) r.kind = 2;
        q.push_back(r);
        if (amode == 3) begin
            r.kind = 2;
            q.push_back(r);
        end
        start = 1'b1; len = 16'(ln); int_mode = 2'(im); frac_en = 1'(fe);
        out_ready = 1'b0; abort = 1'b0;
        tick();
        hs = 0; stc = 0; fin = 0;
        for (int c = 0; c < 300; c++) begin
            start = 1'b0;
            abort = 1'b0;
            if (aborted) begin fin = 1; break; end
            if (done) begin
                if (amode == 3) abort = 1'b1;
                else begin fin = 1; tick(); break; end
            end
            // Busy-time noise on start and config must have no effect.
            start = ($urandom_range(0, 3) == 0);
            len = 16'($urandom); int_mode = 2'($urandom); frac_en = 1'($urandom);
            if (out_valid && hs == stk && stc < stn) begin
                check("stall_remaining", int'(remaining), ln - stk);
                out_ready = 1'b0;
                stc++;
            end else begin
                out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (amode == 1 && out_valid && hs == k) abort = 1'b1;
            if (amode == 2 && int_we && !addb_zero && hs == k) abort = 1'b1;
            if (out_valid && out_ready && !abort) hs++;
            tick();
        end
        start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        if (!fin) begin
            check("span_timeout", 0, 1);
            reset_n = 1'b0;
            tick();
            q.delete();
            reset_n = 1'b1;
            tick();
        end
    endtask

    initial begin
        int ln, fe, im, am, k;
        #3;
        check("reset_outputs_zero",
              int'({busy, done, aborted, daddmode, carry_en, addb_zero, frac_we, int_we, out_valid, remaining}), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("post_reset_busy", int'(busy), 0);
        check("post_reset_remaining", int'(remaining), 0);

        run_span(3, 1, 0, 0, 0, 0, -1, 0);
        run_span(2, 0, 1, 0, 0, 0, -1, 0);
        run_span(0, 1, 2, 0, 0, 0, -1, 0);
        run_span(4, 1, 0, 0, 0, 0, 1, 5);
        run_span(5, 1, 2, 2, 2, 0, -1, 0);
        run_span(3, 0, 3, 0, 0, 0, -1, 0);     // starts in the aborted (idle) cycle
        run_span(4, 1, 1, 1, 1, 0, -1, 0);     // abort with out_ready high in EMIT
        run_span(2, 1, 0, 3, 0, 0, -1, 0);     // abort while in DONE
        tick();

        for (int s = 0; s < 40; s++) begin
            ln = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 7);
            fe = $urandom_range(0, 1);
            im = $urandom_range(0, 3);
            am = $urandom_range(0, 5);
            if (am > 3) am = 0;
            k = 0;
            if (ln == 0 && (am == 1 || am == 2)) am = 0;
            if (am == 2 && ln < 2) am = 0;
            if (am == 1) k = $urandom_range(0, ln - 1);
            if (am == 2) k = $urandom_range(1, ln - 1);
            run_span(ln, fe, im, am, k, 1, ($urandom_range(0, 1) == 1) ? $urandom_range(0, ln) : -1,
                     $urandom_range(1, 4));
            repeat ($urandom_range(0, 2)) tick();
        end

        // Asynchronous reset while a pixel is being presented.
        start = 1'b1; len = 16'd6; int_mode = 2'd0; frac_en = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10 && !out_valid; c++) tick();
        check("mid_span_out_valid", int'(out_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs",
              int'({busy, done, aborted, daddmode, carry_en, addb_zero, frac_we, int_we, out_valid, remaining}), 0);
        q.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        run_span(2, 1, 2, 0, 0, 0, -1, 0);
        repeat (3) tick();
        check("scoreboard_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
